// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter: shares the single VRAM read/write port between the
// display fetch path and the Avalon-MM host, with an optional clear engine.
//
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_disp_req/i_disp_addr    display fetch request and word address
//   o_disp_gnt                display request accepted this cycle
//   o_disp_rvalid/o_disp_rdata display read return (data 0 when not valid)
//   i_host_read/i_host_write  Avalon read/write strobes
//   i_host_addr/_byte_en/_writedata  Avalon address, byte enables, data
//   o_host_waitreq            Avalon waitrequest
//   o_host_readdatavalid/o_host_readdata  host read return
//   i_clear_start/o_clear_busy  clear engine start pulse / busy flag
//   o_ram_*/i_ram_q           VRAM port (read data arrives RD_LAT later)
//
// Build option: define VRAM_CLEAR_EN to include the clear engine.
// Without it, i_clear_start is ignored and o_clear_busy is tied to 0.

module vram_port_arbiter #(
  parameter int DEPTH        = 600,
  parameter int ADDR_W       = 11,
  parameter int RD_LAT       = 2,
  parameter int MAX_DISP_RUN = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_disp_req,
  input  logic [ADDR_W-1:0] i_disp_addr,
  output logic              o_disp_gnt,
  output logic              o_disp_rvalid,
  output logic [31:0]       o_disp_rdata,
  input  logic              i_host_read,
  input  logic              i_host_write,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [3:0]        i_host_byte_en,
  input  logic [31:0]       i_host_writedata,
  output logic              o_host_waitreq,
  output logic              o_host_readdatavalid,
  output logic [31:0]       o_host_readdata,
  input  logic              i_clear_start,
  output logic              o_clear_busy,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [3:0]        o_ram_be,
  output logic [31:0]       o_ram_wdata,
  output logic              o_ram_wren,
  output logic              o_ram_rden,
  input  logic [31:0]       i_ram_q
);

  localparam int RUN_W = $clog2(MAX_DISP_RUN + 1);
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  // ZERO marks a read whose data must be forced to 0 (out-of-range);
  // the parallel r_zown bit says which owner gets it (1 = host).
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DISP = 2'd1,
    TAG_HOST = 2'd2,
    TAG_ZERO = 2'd3
  } tag_e;

  logic              w_clr_act;
  logic [ADDR_W-1:0] w_clr_addr;

`ifdef VRAM_CLEAR_EN
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_e;

  clr_e              r_state;
  logic [ADDR_W-1:0] r_clr_addr;
  logic              r_clr_busy;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_clr_addr <= '0;
      r_clr_busy <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (i_clear_start) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
            r_clr_busy <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (r_clr_addr == LAST) begin
            r_state    <= ST_IDLE;
            r_clr_addr <= '0;
            r_clr_busy <= 1'b0;
          end else begin
            r_clr_addr <= r_clr_addr + ADDR_W'(1);
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_clr_busy <= 1'b0;
        end
      endcase
    end
  end

  assign w_clr_act    = r_clr_busy;
  assign w_clr_addr   = r_clr_addr;
  assign o_clear_busy = r_clr_busy;
`else
  logic w_unused_clear;
  assign w_unused_clear = i_clear_start;
  assign w_clr_act      = 1'b0;
  assign w_clr_addr     = '0;
  assign o_clear_busy   = 1'b0;
`endif

  logic             w_host_req;
  logic             w_host_force;
  logic             w_live;
  logic             w_clr_wr;
  logic             w_disp_gnt;
  logic             w_host_gnt;
  logic             w_disp_ok;
  logic             w_host_ok;
  logic [RUN_W-1:0] r_run;

  assign w_host_req = i_host_read | i_host_write;
  assign w_disp_ok  = i_disp_addr < LIMIT;
  assign w_host_ok  = i_host_addr < LIMIT;

  // Nothing is granted in reset; during a clear only the engine writes.
  assign w_live   = ~i_reset & ~w_clr_act;
  assign w_clr_wr = ~i_reset & w_clr_act;

  // After MAX_DISP_RUN display grants with the host waiting,
  // the host takes the next slot.
  assign w_host_force = w_host_req &
                        (r_run == RUN_W'(MAX_DISP_RUN));
  assign w_disp_gnt   = w_live & i_disp_req & ~w_host_force;
  assign w_host_gnt   = w_live & w_host_req & ~w_disp_gnt;

  assign o_disp_gnt     = w_disp_gnt;
  assign o_host_waitreq = w_host_req & ~w_host_gnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_run <= '0;
    end else if (!w_host_req || w_host_gnt) begin
      r_run <= '0;
    end else if (w_disp_gnt) begin
      r_run <= r_run + RUN_W'(1);
    end
  end

  tag_e w_new_tag;
  logic w_new_zown;

  always_comb begin
    o_ram_addr  = '0;
    o_ram_be    = '0;
    o_ram_wdata = '0;
    o_ram_wren  = 1'b0;
    o_ram_rden  = 1'b0;
    w_new_tag   = TAG_NONE;
    w_new_zown  = 1'b0;
    unique case (1'b1)
      w_clr_wr: begin
        o_ram_addr = w_clr_addr;
        o_ram_be   = 4'b1111;
        o_ram_wren = 1'b1;
      end
      w_disp_gnt: begin
        o_ram_addr = i_disp_addr;
        o_ram_rden = w_disp_ok;
        w_new_tag  = w_disp_ok ? TAG_DISP : TAG_ZERO;
      end
      w_host_gnt: begin
        o_ram_addr = i_host_addr;
        if (i_host_write) begin
          o_ram_be    = i_host_byte_en;
          o_ram_wdata = i_host_writedata;
          o_ram_wren  = w_host_ok;
        end else begin
          o_ram_rden = w_host_ok;
          w_new_tag  = w_host_ok ? TAG_HOST : TAG_ZERO;
          w_new_zown = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  tag_e r_tag  [RD_LAT];
  logic r_zown [RD_LAT];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_tag[i]  <= TAG_NONE;
        r_zown[i] <= 1'b0;
      end
    end else begin
      r_tag[0]  <= w_new_tag;
      r_zown[0] <= w_new_zown;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tag[i]  <= r_tag[i-1];
        r_zown[i] <= r_zown[i-1];
      end
    end
  end

  tag_e        w_out_tag;
  logic        w_out_zown;
  logic        w_out_zero;
  logic [31:0] w_out_data;

  assign w_out_tag  = r_tag[RD_LAT-1];
  assign w_out_zown = r_zown[RD_LAT-1];
  assign w_out_zero = (w_out_tag == TAG_ZERO);
  assign w_out_data = w_out_zero ? 32'd0 : i_ram_q;

  // Returns are suppressed while reset is held so in-flight reads vanish.
  assign o_disp_rvalid = ~i_reset &
                         ((w_out_tag == TAG_DISP) |
                          (w_out_zero & ~w_out_zown));
  assign o_host_readdatavalid = ~i_reset &
                                ((w_out_tag == TAG_HOST) |
                                 (w_out_zero & w_out_zown));

  assign o_disp_rdata    = o_disp_rvalid ? w_out_data : 32'd0;
  assign o_host_readdata = o_host_readdatavalid ?
                           w_out_data : 32'd0;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// tb_vram_port_arbiter: directed scoreboard bench for vram_port_arbiter.
// Includes a 2-cycle-latency byte-enabled VRAM model.

module tb_vram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        disp_req;
  logic [10:0] disp_addr;
  logic        disp_gnt;
  logic        disp_rvalid;
  logic [31:0] disp_rdata;
  logic        host_read;
  logic        host_write;
  logic [10:0] host_addr;
  logic [3:0]  host_be;
  logic [31:0] host_wdata;
  logic        host_waitreq;
  logic        host_rvalid;
  logic [31:0] host_rdata;
  logic        clear_start;
  logic        clear_busy;
  logic [10:0] ram_addr;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic        ram_wren;
  logic        ram_rden;
  logic [31:0] ram_q;

  always #5 clk = ~clk;

  vram_port_arbiter dut (
    .i_clk                (clk),
    .i_reset              (rst),
    .i_disp_req           (disp_req),
    .i_disp_addr          (disp_addr),
    .o_disp_gnt           (disp_gnt),
    .o_disp_rvalid        (disp_rvalid),
    .o_disp_rdata         (disp_rdata),
    .i_host_read          (host_read),
    .i_host_write         (host_write),
    .i_host_addr          (host_addr),
    .i_host_byte_en       (host_be),
    .i_host_writedata     (host_wdata),
    .o_host_waitreq       (host_waitreq),
    .o_host_readdatavalid (host_rvalid),
    .o_host_readdata      (host_rdata),
    .i_clear_start        (clear_start),
    .o_clear_busy         (clear_busy),
    .o_ram_addr           (ram_addr),
    .o_ram_be             (ram_be),
    .o_ram_wdata          (ram_wdata),
    .o_ram_wren           (ram_wren),
    .o_ram_rden           (ram_rden),
    .i_ram_q              (ram_q)
  );

  logic [31:0] mem [0:2047];
  logic [31:0] q1;
  logic [31:0] q2;

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'h5A00_0000 | i;
    q1 = 32'hBAD0_BAD0;
    q2 = 32'hBAD0_BAD0;
  end

  always @(posedge clk) begin
    if (ram_wren)
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    q1 <= ram_rden ? mem[ram_addr] : 32'hBAD0_BAD0;
    q2 <= q1;
  end
  assign ram_q = q2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] d;
    int          c;
  } exp_t;

  exp_t qh[$];
  exp_t qd[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_h(logic [31:0] d);
    exp_t e;
    e.d = d;
    e.c = cyc + 2;
    qh.push_back(e);
  endtask

  task automatic push_d(logic [31:0] d);
    exp_t e;
    e.d = d;
    e.c = cyc + 2;
    qd.push_back(e);
  endtask

  // Monitor: pops the scoreboard whenever a read return is presented.
  always @(negedge clk) begin
    exp_t e;
    if (host_rvalid) begin
      if (qh.size() == 0) begin
        chk("host_unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = qh.pop_front();
        chk("host_rdata", host_rdata, e.d);
        chk("host_rcycle", cyc, e.c);
      end
    end else begin
      chk("host_rdata_idle", host_rdata, 32'd0);
    end
    if (disp_rvalid) begin
      if (qd.size() == 0) begin
        chk("disp_unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = qd.pop_front();
        chk("disp_rdata", disp_rdata, e.d);
        chk("disp_rcycle", cyc, e.c);
      end
    end else begin
      chk("disp_rdata_idle", disp_rdata, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_req    = 1'b0;
    host_read   = 1'b0;
    host_write  = 1'b0;
    clear_start = 1'b0;
  endtask

  initial begin
    int nb;
    int guard;
    logic [10:0] lastaddr;
    logic hg;

    rst = 1'b1;
    idle();
    disp_addr  = '0;
    host_addr  = '0;
    host_be    = 4'hF;
    host_wdata = '0;

    // Requests while in reset: nothing granted, no RAM access.
    tick();
    disp_req  = 1'b1;
    host_read = 1'b1;
    host_addr = 11'd5;
    #1;
    chk("rst_disp_gnt", disp_gnt, 1'b0);
    chk("rst_waitreq", host_waitreq, 1'b1);
    chk("rst_rden", ram_rden, 1'b0);
    chk("rst_wren", ram_wren, 1'b0);
    chk("rst_busy", clear_busy, 1'b0);
    chk("rst_hvalid", host_rvalid, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    idle();

    // Host write then read of addr 5.
    tick();
    host_write = 1'b1;
    host_addr  = 11'd5;
    host_be    = 4'hF;
    host_wdata = 32'hDEADBEEF;
    #1;
    chk("wr5_waitreq", host_waitreq, 1'b0);
    chk("wr5_wren", ram_wren, 1'b1);
    chk("wr5_addr", ram_addr, 11'd5);
    tick();
    host_write = 1'b0;
    host_read  = 1'b1;
    #1;
    chk("rd5_waitreq", host_waitreq, 1'b0);
    chk("rd5_rden", ram_rden, 1'b1);
    push_h(32'hDEADBEEF);
    tick();
    idle();

    // Starvation guard: DDDDH repeating with the host read held.
    tick();
    disp_req  = 1'b1;
    host_read = 1'b1;
    host_addr = 11'd20;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) tick();
      disp_addr = 11'(100 + k);
      #1;
      hg = (k % 5 == 4);
      chk("run_disp_gnt", disp_gnt, !hg);
      chk("run_waitreq", host_waitreq, !hg);
      if (hg) push_h(32'h5A00_0014);
      else push_d(32'h5A00_0000 | (100 + k));
    end
    tick();
    idle();

    // Same-address race: display reads old data, host writes next.
    tick();
    disp_req   = 1'b1;
    disp_addr  = 11'd10;
    host_write = 1'b1;
    host_addr  = 11'd10;
    host_be    = 4'hF;
    host_wdata = 32'h12345678;
    #1;
    chk("race_disp_gnt", disp_gnt, 1'b1);
    chk("race_waitreq", host_waitreq, 1'b1);
    push_d(32'h5A00_000A);
    tick();
    disp_req = 1'b0;
    #1;
    chk("race_host_gnt", host_waitreq, 1'b0);
    chk("race_wren", ram_wren, 1'b1);
    tick();
    host_be    = 4'b0011;
    host_wdata = 32'hFFFFFFFF;
    #1;
    chk("be_wren", ram_wren, 1'b1);
    chk("be_ram_be", ram_be, 4'b0011);
    tick();
    host_write = 1'b0;
    host_read  = 1'b1;
    host_be    = 4'hF;
    push_h(32'h1234FFFF);
    tick();
    idle();

    // Out-of-range accesses.
    tick();
    host_read = 1'b1;
    host_addr = 11'd700;
    #1;
    chk("oor_waitreq", host_waitreq, 1'b0);
    chk("oor_h_rden", ram_rden, 1'b0);
    push_h(32'd0);
    tick();
    host_read = 1'b0;
    disp_req  = 1'b1;
    disp_addr = 11'd650;
    #1;
    chk("oor_disp_gnt", disp_gnt, 1'b1);
    chk("oor_d_rden", ram_rden, 1'b0);
    push_d(32'd0);
    tick();
    idle();

    // Read and write together act as a write; then pipelined reads.
    tick();
    host_read  = 1'b1;
    host_write = 1'b1;
    host_addr  = 11'd30;
    host_wdata = 32'hCAFEF00D;
    #1;
    chk("rw_wren", ram_wren, 1'b1);
    chk("rw_rden", ram_rden, 1'b0);
    tick();
    host_write = 1'b0;
    push_h(32'hCAFEF00D);
    tick();
    host_addr = 11'd5;
    push_h(32'hDEADBEEF);
    tick();
    host_addr = 11'd10;
    push_h(32'h1234FFFF);
    tick();
    idle();
    tick();

`ifdef VRAM_CLEAR_EN
    // Full clear.
    tick();
    clear_start = 1'b1;
    host_read   = 1'b1;
    host_addr   = 11'd5;
    #1;
    chk("clr_start_waitreq", host_waitreq, 1'b0);
    push_h(32'hDEADBEEF);
    tick();
    clear_start = 1'b0;
    disp_req    = 1'b1;
    disp_addr   = 11'd3;
    #1;
    chk("clr_busy_rise", clear_busy, 1'b1);
    chk("clr_disp_stall", disp_gnt, 1'b0);
    chk("clr_host_stall", host_waitreq, 1'b1);
    chk("clr_wren", ram_wren, 1'b1);
    chk("clr_first_addr", ram_addr, 11'd0);
    chk("clr_wdata", ram_wdata, 32'd0);
    idle();
    nb       = 1;
    guard    = 0;
    lastaddr = ram_addr;
    while (1) begin
      tick();
      if (!clear_busy) break;
      nb++;
      lastaddr = ram_addr;
      guard++;
      if (guard > 1000) begin
        chk("clr_timeout", 32'd1, 32'd0);
        break;
      end
    end
    chk("clr_cycles", nb, 600);
    chk("clr_last_addr", lastaddr, 11'd599);
    host_read = 1'b1;
    host_addr = 11'd599;
    #1;
    chk("clr_after_waitreq", host_waitreq, 1'b0);
    push_h(32'd0);
    tick();
    host_addr = 11'd5;
    push_h(32'd0);
    tick();
    host_read  = 1'b0;
    host_write = 1'b1;
    host_addr  = 11'd200;
    host_wdata = 32'h11111111;
    tick();
    host_addr  = 11'd400;
    host_wdata = 32'h44444444;
    tick();
    idle();
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    guard = 0;
    while (!(clear_busy && ram_addr == 11'd300)) begin
      tick();
      guard++;
      if (guard > 1000) begin
        chk("clr2_timeout", 32'd1, 32'd0);
        break;
      end
    end
    rst = 1'b1;
    #1;
    chk("clr2_rst_wren", ram_wren, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    chk("clr2_busy_fall", clear_busy, 1'b0);
    chk("clr2_wren", ram_wren, 1'b0);
    tick();
    host_read = 1'b1;
    host_addr = 11'd200;
    push_h(32'd0);
    tick();
    host_addr = 11'd400;
    push_h(32'h44444444);
    tick();
    idle();
`else
    tick();
    clear_start = 1'b1;
    host_read   = 1'b1;
    host_addr   = 11'd5;
    #1;
    chk("noclr_waitreq", host_waitreq, 1'b0);
    push_h(32'hDEADBEEF);
    tick();
    idle();
    #1;
    chk("noclr_busy", clear_busy, 1'b0);
    chk("noclr_wren", ram_wren, 1'b0);
`endif

    tick();
    tick();

    // Reset with two host reads in flight: both must vanish.
    tick();
    host_read = 1'b1;
    host_addr = 11'd5;
    tick();
    host_addr = 11'd10;
    tick();
    idle();
    rst = 1'b1;
    #1;
    chk("rstf_hvalid0", host_rvalid, 1'b0);
    chk("rstf_hdata0", host_rdata, 32'd0);
    tick();
    #1;
    chk("rstf_hvalid1", host_rvalid, 1'b0);
    tick();
    rst = 1'b0;
    repeat (4) tick();

    chk("host_q_empty", qh.size(), 0);
    chk("disp_q_empty", qd.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vram_port_arbiter.md
# vram_port_arbiter

Shares the single read/write port of the text-mode VRAM between the display fetch path and the Avalon-MM host. It issues at most one RAM access per cycle and returns read data to the owner through a fixed-latency tag pipeline. An optional clear engine can zero the whole VRAM. It sits between the Avalon slave logic and the VRAM port, and keeps display fetches on schedule without starving CPU text updates.

## Interface
- DEPTH, 600: VRAM words (80x30 chars, 4 per word).
- ADDR_W, 11: word address width.
- RD_LAT, 2: RAM read latency in cycles, from address to RAM_Q.
- MAX_DISP_RUN, 4: consecutive display grants allowed while host waits.

- CLK  in  1  system clock (50 MHz).
- RESET  in  1  synchronous, active-high reset.
- DISP_REQ  in  1  display fetch request.
- DISP_ADDR  in  ADDR_W  display word address.
- DISP_GNT  out  1  display request accepted this cycle.
- DISP_RVALID  out  1  display read data valid.
- DISP_RDATA  out  32  display read data; 0 when not valid.
- HOST_READ, HOST_WRITE  in  1  Avalon read/write.
- HOST_ADDR  in  ADDR_W  host word address.
- HOST_BYTE_EN  in  4  byte enables.
- HOST_WRITEDATA  in  32  write data.
- HOST_WAITREQ  out  1  Avalon waitrequest.
- HOST_READDATAVALID  out  1  host read data valid.
- HOST_READDATA  out  32  host read data; 0 when not valid.
- CLEAR_START  in  1  pulse that starts a VRAM clear.
- CLEAR_BUSY  out  1  clear in progress.
- RAM_ADDR  out  ADDR_W; RAM_BE out 4; RAM_WDATA out 32; RAM_WREN out 1; RAM_RDEN out 1  VRAM port.
- RAM_Q  in  32  VRAM read data.

## Operation
- Per cycle, at most one grant. Priority: clear engine > display > host.
- Starvation guard: run counter increments on each display grant while a host request is pending. At MAX_DISP_RUN the host wins the next cycle, then the counter resets to 0. The counter also resets when no host request is pending.
- Grant outputs are combinational from the requests and the arbiter state. HOST_WAITREQ = (HOST_READ|HOST_WRITE) & ~host_grant.
- HOST_READ and HOST_WRITE both high: treated as a write; the read is ignored.
- Host or display address >= DEPTH: the access is granted, but RAM_WREN/RAM_RDEN stay 0. A read still returns valid with data 0.
- Tag pipeline, RD_LAT deep, 2-bit tags: NONE, DISP, HOST, ZERO. On exit, RAM_Q (or 0 for the ZERO tag) goes to the owner's RDATA and that owner's VALID pulses for 1 cycle.
- Clear FSM: IDLE -> CLEAR on CLEAR_START. In CLEAR, write 0 with BE=1111 to addr 0..DEPTH-1, one word per cycle. After the last word, return to IDLE. CLEAR_START during CLEAR is ignored. Display and host are stalled during CLEAR.
- Reset values: all VALIDs 0, RDATAs 0, tags NONE, run counter 0, FSM IDLE, CLEAR_BUSY 0. While RESET is high, all grants are 0 and RAM_WREN/RAM_RDEN are 0.
- RESET mid-operation: in-flight reads are dropped (no VALID). A clear in progress is abandoned, leaving VRAM partially cleared.

## Timing
- Grant cycle T drives RAM_ADDR/RAM_WREN/RAM_RDEN in cycle T.
- Read data is valid in cycle T+RD_LAT. Reads are fully pipelined: one per cycle sustained.
- Writes have no response. A write granted in cycle T is visible to a read granted in cycle T+1.
- A clear of N words occupies exactly DEPTH cycles. CLEAR_BUSY rises the cycle after CLEAR_START and falls the cycle after the last write.

## Configuration
- VRAM_CLEAR_EN defined: clear engine present as described.
- VRAM_CLEAR_EN undefined: no FSM is built. CLEAR_START is ignored, CLEAR_BUSY is tied to 0, and priority is display > host.

## Test plan
- Host write 0xDEADBEEF at addr 5 with BE=1111, then host read addr 5 -> HOST_WAITREQ=0 both cycles; HOST_READDATAVALID 2 cycles after the read grant with data 0xDEADBEEF.
- DISP_REQ held high, host read pending -> 4 DISP_GNT, then 1 host grant, repeating; no cycle has two grants.
- Simultaneous display read of addr 10 and host write of addr 10 -> display granted first and sees old data; host granted the next cycle.
- Host read addr 700 -> granted, RAM_RDEN=0, valid with data 0.
- With VRAM_CLEAR_EN, CLEAR_START then read addr 599 after CLEAR_BUSY falls -> 600 write cycles, read returns 0; RESET asserted at word 300 -> CLEAR_BUSY=0 the next cycle, no pending VALIDs.
- RESET during 2 in-flight host reads -> no HOST_READDATAVALID; outputs are 0.
